uart_boot_loader: RTL and testbench

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

---
 rtl/uart_boot_loader.sv | 136 +++++++++++++
 tb/tb_uart_boot_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART image boot loader writing words to memory (optional macro BOOT_CHECKSUM_EN)
module uart_boot_loader #(
   parameter int MEMORY_SIZE = 2048,
   parameter int MAX_WORDS   = MEMORY_SIZE / 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        core_reset,
   output logic        boot_done,
   output logic        boot_error
);

   localparam logic [7:0] MAGIC = 8'hA5;

`ifdef BOOT_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR} state_t;
   // Once the payload is complete the trailing checksum byte must be checked.
   localparam state_t POST_DATA = CSUM;
`else
   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERROR} state_t;
   localparam state_t POST_DATA = DONE;
`endif

   state_t      state;
   state_t      next_state;
   logic [15:0] len;
   logic [15:0] word_index;
   logic [1:0]  byte_count;
   logic [23:0] word_buf;
   logic [15:0] n_full;
   logic        word_done;
   logic        last_word;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   assign n_full     = {rx_data, len[7:0]};
   assign word_done  = (state == DATA) && rx_valid && (byte_count == 2'd3);
   assign last_word  = (word_index == len - 16'd1);
   assign core_reset = (state != DONE);
   assign boot_done  = (state == DONE);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state decode from the current byte and the length bounds.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:   if (rx_valid && rx_data == MAGIC) next_state = LEN_LO;
         LEN_LO: if (rx_valid) next_state = LEN_HI;
         LEN_HI: if (rx_valid) begin
            if (32'(n_full) > MAX_WORDS) next_state = ERROR;
            else if (n_full == 16'd0)    next_state = POST_DATA;
            else                         next_state = DATA;
         end
         DATA:   if (word_done && last_word) next_state = POST_DATA;
`ifdef BOOT_CHECKSUM_EN
         CSUM:   if (rx_valid) next_state = (rx_data == csum) ? DONE : ERROR;
`endif
         DONE:   next_state = DONE;
         ERROR:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Length capture, word assembly, memory write strobe and sticky error flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_we     <= 1'b0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
         boot_error <= 1'b0;
         len        <= 16'd0;
         word_index <= 16'd0;
         byte_count <= 2'd0;
         word_buf   <= 24'd0;
`ifdef BOOT_CHECKSUM_EN
         csum       <= 8'd0;
`endif
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE: if (rx_valid && rx_data == MAGIC) begin
               boot_error <= 1'b0;
               byte_count <= 2'd0;
               word_index <= 16'd0;
`ifdef BOOT_CHECKSUM_EN
               csum       <= 8'd0;
`endif
            end
            LEN_LO: if (rx_valid) begin
               len[7:0] <= rx_data;
`ifdef BOOT_CHECKSUM_EN
               csum     <= csum ^ rx_data;
`endif
            end
            LEN_HI: if (rx_valid) begin
               len[15:8] <= rx_data;
`ifdef BOOT_CHECKSUM_EN
               csum      <= csum ^ rx_data;
`endif
            end
            DATA: if (rx_valid) begin
               byte_count <= byte_count + 2'd1;
`ifdef BOOT_CHECKSUM_EN
               csum       <= csum ^ rx_data;
`endif
               case (byte_count)
                  2'd0: word_buf[7:0]   <= rx_data;
                  2'd1: word_buf[15:8]  <= rx_data;
                  2'd2: word_buf[23:16] <= rx_data;
                  default: begin
                     // The 4th byte goes straight to the write bus, no extra buffer cycle.
                     mem_we     <= 1'b1;
                     mem_addr   <= {14'd0, word_index, 2'b00};
                     mem_wdata  <= {rx_data, word_buf};
                     word_index <= word_index + 16'd1;
                  end
               endcase
            end
            default: ;
         endcase
         if (next_state == ERROR) boot_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - scoreboard bench for uart_boot_loader (honours BOOT_CHECKSUM_EN)
module tb_uart_boot_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        core_reset;
   logic        boot_done;
   logic        boot_error;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int serial = 0;
   int sent_cyc [int];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          idx;
   } wr_t;
   wr_t exp_q [$];

   uart_boot_loader dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .core_reset (core_reset),
      .boot_done  (boot_done),
      .boot_error (boot_error)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Rising-edge counter used to time write strobes.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic expect_wr(input logic [31:0] addr, input logic [31:0] data, input int idx);
      wr_t e;
      e.addr = addr;
      e.data = data;
      e.idx  = idx;
      exp_q.push_back(e);
   endtask

   task automatic send_seq(input logic [7:0] b [$], input bit b2b);
      foreach (b[i]) begin
         @(negedge clk);
         rx_data  = b[i];
         rx_valid = 1'b1;
         sent_cyc[serial] = cyc + 1;
         serial++;
         if (!b2b) begin
            @(negedge clk);
            rx_valid = 1'b0;
         end
      end
      if (b2b) begin
         @(negedge clk);
         rx_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Monitor: every write strobe must match the next expected write and land on the cycle after its 4th byte.
   always @(negedge clk) begin
      wr_t e;
      if (reset && mem_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%0h:%0h expected=none", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("write_addr_data", {mem_addr, mem_wdata}, {e.addr, e.data});
            check("write_cycle", 64'(cyc), 64'(sent_cyc[e.idx]));
         end
      end
   end

   initial begin
      logic [7:0] q [$];
      int s;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_core_reset", core_reset, 1);
      check("rst_boot_done", boot_done, 0);
      check("rst_boot_error", boot_error, 0);
      reset = 1'b1;

      // Noise then a valid two-word image
      expect_wr(32'h0, 32'h00000013, serial + 8);
      expect_wr(32'h4, 32'h0000006F, serial + 12);
      q = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
      q.push_back(8'h7E);
`endif
      send_seq(q, 1'b0);
      @(negedge clk);
      check("load_boot_done", boot_done, 1);
      check("load_core_reset", core_reset, 0);
      check("load_boot_error", boot_error, 0);
      check("hold_mem_we", mem_we, 0);
      check("hold_mem_addr", mem_addr, 32'h4);
      check("hold_mem_wdata", mem_wdata, 32'h6F);

      // Bytes in DONE are ignored
      q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      send_seq(q, 1'b0);
      check("done_ignores_boot_done", boot_done, 1);

      // Asynchronous reset clears outputs without a clock edge
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("async_rst_mem_addr", mem_addr, 0);
      check("async_rst_mem_wdata", mem_wdata, 0);
      check("async_rst_boot_done", boot_done, 0);
      check("async_rst_core_reset", core_reset, 1);
      @(negedge clk);
      reset = 1'b1;

      // Oversize image: N = 513
      q = '{8'hA5, 8'h01, 8'h02};
      send_seq(q, 1'b0);
      check("oversize_boot_error", boot_error, 1);
      check("oversize_core_reset", core_reset, 1);
      check("oversize_boot_done", boot_done, 0);
      @(negedge clk);
      check("error_sticky_idle", boot_error, 1);

      // Zero-length image; the magic byte clears the error
      q = '{8'hA5};
      send_seq(q, 1'b0);
      check("magic_clears_error", boot_error, 0);
      q = '{8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
      q.push_back(8'h00);
`endif
      send_seq(q, 1'b0);
      check("zero_len_boot_done", boot_done, 1);
      check("zero_len_core_reset", core_reset, 0);
      do_reset();

`ifdef BOOT_CHECKSUM_EN
      // Bad checksum: words are written, then the image is rejected
      expect_wr(32'h0, 32'h00000013, serial + 6);
      expect_wr(32'h4, 32'h0000006F, serial + 10);
      q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00};
      send_seq(q, 1'b0);
      check("bad_csum_boot_error", boot_error, 1);
      check("bad_csum_core_reset", core_reset, 1);
      check("bad_csum_boot_done", boot_done, 0);
      @(negedge clk);
      expect_wr(32'h0, 32'h00000013, serial + 6);
      expect_wr(32'h4, 32'h0000006F, serial + 10);
      q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};
      send_seq(q, 1'b0);
      check("retry_boot_done", boot_done, 1);
      check("retry_boot_error", boot_error, 0);
      do_reset();
`endif

      // Reset after two payload bytes discards the partial image
      q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
      send_seq(q, 1'b0);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_mem_we", mem_we, 0);
      check("mid_rst_boot_done", boot_done, 0);
      check("mid_rst_core_reset", core_reset, 1);

      // Release reset with the magic already on the bus, then stream back-to-back bytes
      @(negedge clk);
      s = serial;
      reset    = 1'b1;
      rx_data  = 8'hA5;
      rx_valid = 1'b1;
      sent_cyc[serial] = cyc + 1;
      serial++;
      expect_wr(32'h0, 32'h44332211, s + 6);
      expect_wr(32'h4, 32'h88776655, s + 10);
      q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      send_seq(q, 1'b1);
`ifdef BOOT_CHECKSUM_EN
      q = '{8'h8A};
      send_seq(q, 1'b0);
`endif
      check("fresh_boot_done", boot_done, 1);
      check("fresh_core_reset", core_reset, 0);

      repeat (3) @(negedge clk);
      check("all_writes_seen", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
